fir_decim_buffer: RTL

Output stage placed directly after the 4-tap FIR filter. Takes the filter's 10-bit result stream and keeps one sample in every DECIM. Kept samples go into a small first-word-fall-through buffer, which a downstream consumer drains under a valid/ready handshake. The block also reports buffer occupancy and a sticky overflow flag, so a stalled consumer is visible rather than silently dropping samples.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_decim_buffer_if.sv | 29 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/fir_decim_buffer.sv | 78 +++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Constants shared by the 4-tap FIR filter and the decimating output buffer.
package fir_pkg;

  localparam int unsigned FIR_DW   = 10;
  localparam int unsigned FIR_TAPS = 4;
  localparam int unsigned FIR_CW   = 8;

  // Symmetric low-pass taps; the filter's output is FIR_DW bits wide.
  localparam logic signed [FIR_CW-1:0] FIR_C0 = 8'sd16;
  localparam logic signed [FIR_CW-1:0] FIR_C1 = 8'sd48;
  localparam logic signed [FIR_CW-1:0] FIR_C2 = 8'sd48;
  localparam logic signed [FIR_CW-1:0] FIR_C3 = 8'sd16;

endpackage

// File: rtl/fir_decim_buffer_if.sv
// Sample-in / sample-out handshake bundle of the decimating output buffer.
interface fir_decim_buffer_if
  import fir_pkg::*;
#(
  parameter int unsigned DW    = FIR_DW,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          clr_ovf;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (
    output in_valid, in_data, out_ready, clr_ovf,
    input  out_valid, out_data, level, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready, clr_ovf,
    output out_valid, out_data, level, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; exposes the next head so the owner can register it.
module sync_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       next_valid_c_o,
  output logic [DW-1:0]              next_head_c_o,
  output logic                       drop_c_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q;
  logic          full_c, pop_acc_c, push_acc_c;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    full_c     = (level_q == LW'(DEPTH));
    pop_acc_c  = pop_i & valid_q;
    push_acc_c = push_i & (~full_c | pop_acc_c);
    drop_c_o   = push_i & full_c & ~pop_acc_c;

    wr_ptr_d = push_acc_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push_acc_c && !pop_acc_c) begin
      level_d = level_q + LW'(1);
    end else if (!push_acc_c && pop_acc_c) begin
      level_d = level_q - LW'(1);
    end

    next_valid_c_o = (level_d != '0);
    // Bypass the write when the new head is the slot being written this edge.
    next_head_c_o  = (push_acc_c && (rd_ptr_d == wr_ptr_q)) ? wdata_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= next_valid_c_o;
    end
  end

  // Storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_acc_c) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign valid_o = valid_q;
  assign level_o = level_q;

endmodule

// File: rtl/fir_decim_buffer.sv
// Keeps one FIR sample in every DECIM valid samples and buffers it for a
// valid/ready consumer, with occupancy and a sticky overflow flag.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int unsigned DW    = FIR_DW,
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  fir_decim_buffer_if.slave   bus
);
  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [PW-1:0] phase_q, phase_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          keep_c;
  logic          fifo_valid;
  logic [LW-1:0] fifo_level;
  logic          next_valid_c;
  logic [DW-1:0] next_head_c;
  logic          drop_c;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst_n          (rst),
    .push_i         (keep_c),
    .wdata_i        (bus.in_data),
    .pop_i          (bus.out_ready),
    .valid_o        (fifo_valid),
    .level_o        (fifo_level),
    .next_valid_c_o (next_valid_c),
    .next_head_c_o  (next_head_c),
    .drop_c_o       (drop_c)
  );

  // Phase counts valid samples only; it advances even when the kept sample is dropped.
  always_comb begin
    keep_c  = bus.in_valid && (phase_q == '0);
    phase_d = phase_q;
    if (bus.in_valid) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end

    overflow_d = overflow_q;
    if (drop_c) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end

    out_data_d = next_valid_c ? next_head_c : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = out_data_q;
  assign bus.level     = fifo_level;
  assign bus.overflow  = overflow_q;

endmodule
